shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle shift unit with a valid/ready handshake on both sides. Takes
//  an operand, a shift amount and an op, then runs one log-shifter stage per
//  clock: stage k shifts by 2^k when amount bit k is set.
//  Sits beside the ALU and serves shift ops where a single-cycle 5-stage
//  barrel shifter would break timing. Latency is fixed, so the pipeline
//  scheduler can plan around it.
// PARAMETERS
//  WIDTH    32  operand/result width in bits
//  SHAMT_W  5   shift-amount width; also the number of stages (WIDTH = 2**SHAMT_W)
// PORTS
//  clock      in   1        single clock; all state changes on its rising edge
//  reset      in   1        asynchronous, active-low; clears all state immediately
//  in_valid   in   1        request present
//  in_ready   out  1        sequencer can accept a request (high in IDLE only)
//  in_data    in   WIDTH    operand
//  in_shamt   in   SHAMT_W  shift amount
//  in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
//  flush      in   1        synchronous abort; discards any in-flight operation
//  busy       out  1        high in SHIFT or DONE
//  out_valid  out  1        result valid (high in DONE only)
//  out_ready  in   1        consumer accepts the result
//  out_data   out  WIDTH    result; held stable while out_valid=1
// BEHAVIOUR
//  Reset (reset=0, async):
//    state=IDLE, stage=0, data/shamt/op regs=0.
//    Outputs: in_ready=1, busy=0, out_valid=0, out_data=0.
//  States: IDLE, SHIFT, DONE.
//  IDLE:
//    On in_valid&in_ready: latch data, shamt and op; stage<=0; go to SHIFT.
//  SHIFT:
//    Each cycle, if shamt[stage]=1, shift data by 2^stage per op:
//      SLL  zero fill at the LSB end.
//      SRL  zero fill at the MSB end.
//      SRA  fill with data[WIDTH-1] (the operand sign, preserved by every stage).
//      ROL  bits shifted out of the MSB end re-enter at the LSB end.
//    If shamt[stage]=0, data is held. stage<=stage+1.
//    When stage==SHAMT_W-1: apply the final stage and go to DONE.
//  DONE:
//    out_valid=1, out_data=data. On out_ready, go to IDLE.
//    out_valid and out_data hold unchanged while out_ready=0 (backpressure).
//  Latency:
//    Accept edge T -> out_valid=1 after edge T+SHAMT_W (5 clocks), for every shamt.
//    shamt=0 still takes the full latency.
//  Throughput: the earliest next accept is the cycle after the out handshake
//    (min 7 cycles per op). There is no accept in the DONE cycle.
//  Registered control: in_ready is a registered state decode with no
//    combinational path from out_ready.
//  flush=1 in any state:
//    Next state is IDLE and stage=0; the result is lost.
//    out_valid=0 from the following cycle.
//    flush has priority over an in/out handshake in the same cycle; the request
//    is not accepted.
//  Reset asserted mid-SHIFT/DONE: immediate return to the reset values;
//    no stale out_valid after release.
//  Inputs are sampled only at accept. Changes to in_* during SHIFT have no effect.
// TESTING
//  1. SLL 0x0000_0001 by 31 -> out_data 0x8000_0000, out_valid 5 clocks after accept.
//  2. SRA 0x8000_00F0 by 4 -> 0xF800_000F; SRL same -> 0x0800_000F.
//  3. ROL 0x8000_0001 by 1 -> 0x0000_0003; shamt=0 -> operand unchanged, latency still 5.
//  4. Hold out_ready=0 for 3 cycles in DONE -> out_data stable, in_ready=0 throughout,
//     and a second in_valid is not accepted until the handshake completes.
//  5. flush at SHIFT stage 2 -> IDLE next cycle, out_valid never rises, the next op is correct.
//  6. Drop reset mid-SHIFT -> busy=0, in_ready=1, out_data=0 immediately;
//     a subsequent op completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Purpose: multi-cycle log shifter (SLL/SRL/SRA/ROL), one 2^k stage per clock.
// Latency: accept edge T -> out_valid after edge T+SHAMT_W, independent of shamt.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clock, reset            rising-edge clock; async active-low reset
//   in_valid/in_ready       request handshake; in_data, in_shamt, in_op sampled at accept
//   flush                   synchronous abort back to IDLE, beats any handshake
//   busy                    high while an operation is in SHIFT or DONE
//   out_valid/out_ready     result handshake; out_data stable while out_valid
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic               flush,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int STG_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(SHAMT_W - 1);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   step;

  // One stage of the log shifter. Each stage uses a constant shift distance,
  // so the selected path is a small mux instead of a full barrel shifter.
  always_comb begin
    step = data_q;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (int'(stage_q) == k) begin
        case (op_q)
          OP_SLL: step = data_q << (1 << k);
          OP_SRL: step = data_q >> (1 << k);
          OP_SRA: step = $signed(data_q) >>> (1 << k);
          OP_ROL: step = (data_q << (1 << k)) | (data_q >> (WIDTH - (1 << k)));
          default: step = data_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    if (flush) begin
      // Abort wins over both handshakes; the operand registers are left as-is
      // because nothing observes them until the next accept overwrites them.
      state_d = IDLE;
      stage_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d  = in_data;
            shamt_d = in_shamt;
            op_d    = in_op;
            stage_d = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (shamt_q[stage_q]) data_d = step;
          stage_d = stage_q + STG_W'(1);
          if (stage_q == LAST_STAGE) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // All handshake outputs are pure decodes of the state register.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        flush;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];

  logic        ordy_rand = 1'b0;
  logic        ordy_fix  = 1'b1;
  logic        prev_ov   = 1'b0;
  logic [31:0] last_od   = '0;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .flush     (flush),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Consumer: random or fixed out_ready, updated away from both clock edges.
  initial out_ready = 1'b1;
  always @(posedge clock) begin
    #2;
    out_ready = ordy_rand ? ($urandom_range(0, 3) != 0) : ordy_fix;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model: shifts by the whole amount at once, bit by bit.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
    logic [31:0] r;
    r = d;
    case (op)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: for (int i = 0; i < s; i++) r = {d[31], r[31:1]};
      default: for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
    endcase
    return r;
  endfunction

  // Monitor: latency on each rising out_valid, hold stability, result on handshake.
  always @(negedge clock) begin
    if (!reset) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
        else chk("latency", 32'(cyc - acc_q.pop_front()), 32'd5);
      end
      if (out_valid && prev_ov) chk("hold_data", out_data, last_od);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'(out_valid), 32'd0);
        else chk("result", out_data, exp_q.pop_front());
      end
      prev_ov = out_valid;
      last_od = out_data;
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                      input logic [31:0] expv);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc + 1);
    end
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got still running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  op;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_shamt = '0;
    in_op    = '0;
    flush    = 1'b0;
    #3;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    send(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    send(32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F);
    send(32'h8000_00F0, 5'd4,  2'b01, 32'h0800_000F);
    send(32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003);
    send(32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF);
    send(32'h1234_5678, 5'd16, 2'b11, 32'h5678_1234);
    wait_idle();

    // Backpressure: result held three cycles, second request waits.
    ordy_fix = 1'b0;
    step();
    send(32'hA5A5_0F0F, 5'd8, 2'b01, 32'h00A5_A50F);
    in_valid = 1'b1;
    in_data  = 32'h0000_00FF;
    in_shamt = 5'd3;
    in_op    = 2'b00;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clock);
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(negedge clock);
    end
    step();
    ordy_fix = 1'b1;
    send(32'h0000_00FF, 5'd3, 2'b00, 32'h0000_07F8);
    wait_idle();

    // Flush at stage 2: no result, back in IDLE on the next cycle.
    send(32'hFFFF_0000, 5'd7, 2'b00, 32'h0000_0000);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy",     32'(busy),     32'd0);
    for (int i = 0; i < 8; i++) step();
    send(32'h0F00_0000, 5'd5, 2'b10, 32'h0078_0000);
    wait_idle();

    // Flush beats an accept in the same cycle.
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_prio_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-shift.
    send(32'h1357_9BDF, 5'd9, 2'b11, 32'h0);
    step();
    step();
    reset = 1'b0;
    #1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_data",  out_data,       32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    step();
    reset = 1'b1;
    step();
    send(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    wait_idle();

    // Random traffic with a randomly stalling consumer.
    ordy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d  = $urandom;
      s  = 5'($urandom);
      op = 2'($urandom);
      send(d, s, op, ref_shift(d, int'(s), op));
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle();
    ordy_rand = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
